// File: rtl/fp32_add_pipe.sv
// Pipelined IEEE-754 single-precision adder: compare, align/add, normalize, pack.
// No NaN/Inf/denormal handling; results truncate, and overflow or underflow saturates.
module fp32_add_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] num1,
    input  logic [31:0] num2,
    output logic        out_valid,
    output logic [31:0] sum
);

    // ---------------- stage 1: compare (floatcmp) ----------------
    logic [7:0]  exp1, exp2;
    logic [23:0] sig1, sig2;
    logic        s;

    logic        s1_sign_d,    s1_sign_q;
    logic        s1_parity_d,  s1_parity_q;
    logic [7:0]  s1_baseexp_d, s1_baseexp_q;
    logic [7:0]  s1_dexp_d,    s1_dexp_q;
    logic [23:0] s1_big_d,     s1_big_q;
    logic [23:0] s1_small_d,   s1_small_q;

    always_comb begin
        exp1 = num1[30:23];
        exp2 = num2[30:23];
        sig1 = (exp1 == 8'd0) ? 24'd0 : {1'b1, num1[22:0]};
        sig2 = (exp2 == 8'd0) ? 24'd0 : {1'b1, num2[22:0]};
        // Raw {exp,frac} bits order by exponent first, then fraction.
        s    = (num2[30:0] > num1[30:0]);

        s1_parity_d = ~(num1[31] ^ num2[31]);
        if (s) begin
            s1_sign_d    = num2[31];
            s1_baseexp_d = exp2;
            s1_big_d     = sig2;
            s1_small_d   = sig1;
        end else begin
            s1_sign_d    = num1[31];
            s1_baseexp_d = exp1;
            s1_big_d     = sig1;
            s1_small_d   = sig2;
        end
        s1_dexp_d = (exp1 >= exp2) ? (exp1 - exp2) : (exp2 - exp1);
    end

    // ---------------- stage 2: align and add (floatcalcadd) ----------------
    logic [23:0] small_sh;

    logic        s2_sign_d,    s2_sign_q;
    logic [7:0]  s2_baseexp_d, s2_baseexp_q;
    logic [24:0] s2_val_d,     s2_val_q;

    always_comb begin
        small_sh     = (s1_dexp_q >= 8'd24) ? 24'd0 : (s1_small_q >> s1_dexp_q);
        s2_sign_d    = s1_sign_q;
        s2_baseexp_d = s1_baseexp_q;
        if (s1_parity_q)
            s2_val_d = {1'b0, s1_big_q} + {1'b0, small_sh};
        else
            s2_val_d = {1'b0, s1_big_q} - {1'b0, small_sh};
    end

    // ---------------- stage 3: normalize and exponent adjust ----------------
    logic [4:0]  lz;
    logic [23:0] mant;

    logic               s3_sign_d, s3_sign_q;
    logic               s3_zero_d, s3_zero_q;
    logic signed [9:0]  s3_exp_d,  s3_exp_q;
    logic [22:0]        s3_frac_d, s3_frac_q;

    always_comb begin
        lz = 5'd0;
        // Ascending scan so the highest set bit determines the count.
        for (int i = 0; i < 24; i++) begin
            if (s2_val_q[i])
                lz = 5'(23 - i);
        end

        s3_sign_d = s2_sign_q;
        s3_zero_d = (s2_val_q == 25'd0);
        if (s2_val_q[24]) begin
            mant     = s2_val_q[24:1];
            s3_exp_d = $signed({2'b00, s2_baseexp_q}) + 10'sd1;
        end else begin
            mant     = s2_val_q[23:0] << lz;
            s3_exp_d = $signed({2'b00, s2_baseexp_q}) - $signed({5'b00000, lz});
        end
        s3_frac_d = mant[22:0];
    end

    // ---------------- output pack ----------------
    logic [31:0] sum_d, sum_q;
    logic [2:0]  vld_q;
    logic        out_valid_q;

    always_comb begin
        if (s3_zero_q)
            sum_d = 32'h0000_0000;
        else if (s3_exp_q >= 10'sd255)
            sum_d = {s3_sign_q, 8'hFF, 23'h0};
        else if (s3_exp_q <= 10'sd0)
            sum_d = 32'h0000_0000;
        else
            sum_d = {s3_sign_q, s3_exp_q[7:0], s3_frac_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q        <= 3'b000;
            out_valid_q  <= 1'b0;
            sum_q        <= 32'h0;
            s1_sign_q    <= 1'b0;
            s1_parity_q  <= 1'b0;
            s1_baseexp_q <= 8'h0;
            s1_dexp_q    <= 8'h0;
            s1_big_q     <= 24'h0;
            s1_small_q   <= 24'h0;
            s2_sign_q    <= 1'b0;
            s2_baseexp_q <= 8'h0;
            s2_val_q     <= 25'h0;
            s3_sign_q    <= 1'b0;
            s3_zero_q    <= 1'b0;
            s3_exp_q     <= 10'sd0;
            s3_frac_q    <= 23'h0;
        end else begin
            vld_q        <= {vld_q[1:0], in_valid};
            out_valid_q  <= vld_q[2];
            if (vld_q[2])
                sum_q    <= sum_d;
            s1_sign_q    <= s1_sign_d;
            s1_parity_q  <= s1_parity_d;
            s1_baseexp_q <= s1_baseexp_d;
            s1_dexp_q    <= s1_dexp_d;
            s1_big_q     <= s1_big_d;
            s1_small_q   <= s1_small_d;
            s2_sign_q    <= s2_sign_d;
            s2_baseexp_q <= s2_baseexp_d;
            s2_val_q     <= s2_val_d;
            s3_sign_q    <= s3_sign_d;
            s3_zero_q    <= s3_zero_d;
            s3_exp_q     <= s3_exp_d;
            s3_frac_q    <= s3_frac_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;

endmodule

// File: tb/tb_fp32_add_pipe.sv
// Scoreboard bench for fp32_add_pipe: directed vectors with hand-computed sums;
// a monitor pops expectations and checks value and 3-edge latency.
module tb_fp32_add_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] num1, num2;
    logic        out_valid;
    logic [31:0] sum;

    fp32_add_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .num1      (num1),
        .num2      (num2),
        .out_valid (out_valid),
        .sum       (sum)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          edge_no;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   edge_n = 0;

    // Monitor: count edges, sample 1 time unit after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            edge_n++;
            #1;
            if (out_valid) begin
                total++;
                if (sbq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_valid edge=%0d got sum=%h, required no output", edge_n, sum);
                end else begin
                    e = sbq.pop_front();
                    if (sum !== e.res || edge_n != e.edge_no + 3) begin
                        bad++;
                        $display("FAIL %s got sum=%h at edge %0d, required %h at edge %0d",
                                 e.name, sum, edge_n, e.res, e.edge_no + 3);
                    end
                end
            end else if (sbq.size() > 0 && edge_n >= sbq[0].edge_no + 3) begin
                total++;
                bad++;
                e = sbq.pop_front();
                $display("FAIL %s missing out_valid at edge %0d, required %h", e.name, edge_n, e.res);
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input string nm);
        @(negedge clk);
        num1     = a;
        num2     = b;
        in_valid = 1'b1;
        sbq.push_back('{res: r, edge_no: edge_n + 1, name: nm});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        num1     = 32'h0;
        num2     = 32'h0;
        repeat (3) @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || sum !== 32'h0) begin
            bad++;
            $display("FAIL reset_state got out_valid=%b sum=%h, required 0 00000000", out_valid, sum);
        end
        rst = 1'b0;

        // Single-shot, then back-to-back directed vectors
        issue(32'h3F800000, 32'h3F800000, 32'h40000000, "one_plus_one");
        idle(4);
        issue(32'h40400000, 32'h40A00000, 32'h41000000, "three_plus_five");
        issue(32'h3FC00000, 32'hBF000000, 32'h3F800000, "sub_1p5_0p5");
        issue(32'hBF000000, 32'h3FC00000, 32'h3F800000, "sub_swapped");
        issue(32'h3F800000, 32'hBF800000, 32'h00000000, "cancel_pos_zero");
        issue(32'hC0000000, 32'h40000000, 32'h00000000, "cancel_neg_first");
        issue(32'h3F800000, 32'h30800000, 32'h3F800000, "dexp_30");
        issue(32'h00000000, 32'hC1200000, 32'hC1200000, "zero_operand");
        issue(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, "overflow");
        issue(32'h00800000, 32'h80C00000, 32'h00000000, "underflow");
        issue(32'h41200000, 32'hC0A00000, 32'h40A00000, "ten_minus_five");
        issue(32'h3F800000, 32'h33800000, 32'h3F800000, "dexp_24_drop");
        issue(32'h3F800000, 32'h34000000, 32'h3F800001, "dexp_23_keep");
        issue(32'h00800000, 32'h00800000, 32'h01000000, "min_norm_carry");
        issue(32'h7F800000, 32'h00000000, 32'h7F800000, "exp255_ordinary");
        idle(5);

        // Reset pulse on the 4th of six back-to-back inputs drops in-flight ops
        issue(32'h3F800000, 32'h3F800000, 32'h40000000, "rst_burst_a");
        issue(32'h40400000, 32'h40A00000, 32'h41000000, "rst_burst_b");
        issue(32'h3FC00000, 32'hBF000000, 32'h3F800000, "rst_burst_c");
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        num1     = 32'h41200000;
        num2     = 32'hC0A00000;
        sbq.delete();
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || sum !== 32'h0) begin
            bad++;
            $display("FAIL mid_reset_state got out_valid=%b sum=%h, required 0 00000000", out_valid, sum);
        end
        rst = 1'b0;
        num1     = 32'h00000000;
        num2     = 32'hC1200000;
        sbq.push_back('{res: 32'hC1200000, edge_no: edge_n + 1, name: "post_rst_e"});
        issue(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, "post_rst_f");
        idle(1);

        for (int i = 0; i < 20 && sbq.size() > 0; i++)
            @(negedge clk);
        idle(2);
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL drain got %0d pending, required 0", sbq.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
